// File: rtl/jt03_wrseq.sv
// Register-write sequencer for the YM2203-mode core.
// Queues (register, value) pairs and replays each one on the core bus as an
// address write, a fixed settle wait, a data write, then busy-flag polling.
//
// Host handshake: an entry is pushed on any clk edge where wr_valid and
// wr_ready are both high. wr_ready depends only on FIFO fullness and flush,
// never on wr_valid. cen does not gate the FIFO.
module jt03_wrseq #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int ADDR_WAIT = 17,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_reg,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_err,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          timeout_err,
  output logic [7:0]    core_din,
  output logic          core_addr,
  output logic          core_cs_n,
  output logic          core_wr_n,
  input  logic [7:0]    core_dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AWR   = 3'd1,
    S_AWAIT = 3'd2,
    S_DWR   = 3'd3,
    S_POLL  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      hold_reg_q, hold_reg_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            err_q, err_d;
  logic            set_err;
  logic [7:0]      din_q, din_d;
  logic            addr_q, addr_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full, push, pop;
  logic [15:0]     head;

  // Only the busy flag of the status byte matters to the sequencer.
  logic            unused_dout;
  assign unused_dout = ^core_dout[6:0];

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign wr_ready = !full && !flush;
  assign push     = wr_valid && wr_ready;
  assign pop      = cen && (state_q == S_IDLE) && (count_q != '0);
  assign head     = mem[rptr_q];

  // FIFO storage; contents need no reset because count_q guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {wr_reg, wr_data};
  end

  // FIFO pointers and occupancy; flush drops queued entries and any push.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Sequencer next state: advances only on cen edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_reg_d  = hold_reg_q;
    hold_data_d = hold_data_q;
    set_err     = 1'b0;
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            hold_reg_d  = head[15:8];
            hold_data_d = head[7:0];
            state_d     = S_AWR;
          end
        end
        S_AWR: begin
          state_d = S_AWAIT;
          cnt_d   = 8'(ADDR_WAIT);
        end
        S_AWAIT: begin
          if (cnt_q == 8'd1) state_d = S_DWR;
          else               cnt_d   = cnt_q - 8'd1;
        end
        S_DWR: begin
          state_d = S_POLL;
          cnt_d   = 8'(TIMEOUT);
        end
        S_POLL: begin
          if (!core_dout[7]) begin
            state_d = S_IDLE;
          end else if (cnt_q == 8'd1) begin
            set_err = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Bus outputs are a registered decode of the next state so each phase
  // starts on the same cen edge as the state it belongs to.
  always_comb begin
    din_d  = din_q;
    addr_d = addr_q;
    cs_n_d = cs_n_q;
    wr_n_d = wr_n_q;
    if (cen) begin
      din_d  = 8'd0;
      addr_d = 1'b0;
      cs_n_d = 1'b1;
      wr_n_d = 1'b1;
      case (state_d)
        S_AWR: begin
          din_d  = hold_reg_d;
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
        S_DWR: begin
          din_d  = hold_data_d;
          addr_d = 1'b1;
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
        S_POLL: begin
          cs_n_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (set_err)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
  end

  // All sequencer, FIFO-control and bus registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      hold_reg_q  <= 8'd0;
      hold_data_q <= 8'd0;
      err_q       <= 1'b0;
      din_q       <= 8'd0;
      addr_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_reg_q  <= hold_reg_d;
      hold_data_q <= hold_data_d;
      err_q       <= err_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  assign level       = count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign timeout_err = err_q;
  assign core_din    = din_q;
  assign core_addr   = addr_q;
  assign core_cs_n   = cs_n_q;
  assign core_wr_n   = wr_n_q;

endmodule

// File: tb/tb_jt03_wrseq.sv
// Directed bench for jt03_wrseq: bus phase timing, FIFO fill, busy polling,
// timeout, cen pulsing, flush and mid-sequence reset.
module tb_jt03_wrseq;

  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen = 1'b0;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_err;
  logic [3:0] level;
  logic       busy;
  logic       timeout_err;
  logic [7:0] core_din;
  logic       core_addr;
  logic       core_cs_n;
  logic       core_wr_n;
  logic [7:0] core_dout;

  int checks = 0;
  int errors = 0;
  int unexpected = 0;
  int cen_div = 1;
  int cen_ph = 0;
  bit new_per = 1'b0;

  logic [8:0] exp_q[$];

  jt03_wrseq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .flush       (flush),
    .clr_err     (clr_err),
    .level       (level),
    .busy        (busy),
    .timeout_err (timeout_err),
    .core_din    (core_din),
    .core_addr   (core_addr),
    .core_cs_n   (core_cs_n),
    .core_wr_n   (core_wr_n),
    .core_dout   (core_dout)
  );

  // ---------------- clock / cen ----------------
  always #5 clk = ~clk;

  // cen_div=0 holds cen low, otherwise cen is high one clk in cen_div.
  always @(negedge clk) begin
    if (cen_div == 0) begin
      cen = 1'b0;
    end else begin
      cen_ph = (cen_ph + 1 >= cen_div) ? 0 : cen_ph + 1;
      cen = (cen_ph == 0);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bus_phase();
    if (core_cs_n) return 0;
    if (!core_wr_n) return core_addr ? 2 : 1;
    return 3;
  endfunction

  // ---------------- core-side scoreboard ----------------
  always @(posedge clk) new_per = cen;

  // One record per write phase: taken on the first negedge after a cen edge.
  always @(negedge clk) begin
    if (new_per && !core_cs_n && !core_wr_n) begin
      if (exp_q.size() == 0) unexpected++;
      else chk("bus_wr", {23'd0, core_addr, core_din}, {23'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] r, input logic [7:0] d, input bit track);
    wr_valid = 1'b1;
    wr_reg   = r;
    wr_data  = d;
    if (track) begin
      exp_q.push_back({1'b0, r});
      exp_q.push_back({1'b1, d});
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph, output int n);
    n = 0;
    while (bus_phase() != ph && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("wait_phase_timeout", bus_phase(), ph);
  endtask

  task automatic phase_len(input int ph, output int n);
    n = 0;
    while (bus_phase() == ph && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("phase_len_timeout", bus_phase(), 32'hff);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("idle_timeout", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_reg    = 8'd0;
    wr_data   = 8'd0;
    flush     = 1'b0;
    clr_err   = 1'b0;
    core_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", core_cs_n, 1);
    chk("rst_wr_n", core_wr_n, 1);
    chk("rst_addr", core_addr, 0);
    chk("rst_din", core_din, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", wr_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic single write, cen=1.
    push(8'h28, 8'hF0, 1'b1);
    chk("t1_level1", level, 1);
    @(negedge clk);
    chk("t1_awr_phase", bus_phase(), 1);
    chk("t1_awr_din", core_din, 8'h28);
    phase_len(1, n);
    chk("t1_awr_len", n, 1);
    phase_len(0, n);
    chk("t1_await_len", n, 17);
    chk("t1_dwr_addr", core_addr, 1);
    chk("t1_dwr_din", core_din, 8'hF0);
    phase_len(2, n);
    chk("t1_dwr_len", n, 1);
    chk("t1_poll_din", core_din, 0);
    phase_len(3, n);
    chk("t1_poll_len", n, 1);
    chk("t1_busy_end", busy, 0);

    // Fill the FIFO with cen held low, then a 9th push.
    cen_div = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 8'hA0 + 8'(i), 1'b1);
    chk("t2_level8", level, 8);
    chk("t2_ready_full", wr_ready, 0);
    push(8'h55, 8'h66, 1'b0);
    chk("t2_level8_after9", level, 8);
    cen_div = 1;
    wait_idle();
    chk("t2_all_written", exp_q.size(), 0);

    // Busy for 10 polls then clear.
    push(8'h40, 8'h11, 1'b1);
    wait_phase(2, n);
    core_dout = 8'h80;
    wait_phase(3, n);
    repeat (10) @(negedge clk);
    core_dout = 8'h00;
    phase_len(3, n);
    chk("t3_poll_len", 10 + n, 11);
    chk("t3_no_err", timeout_err, 0);
    wait_idle();

    // Busy forever: timeout, next entry still proceeds, then clear flag.
    push(8'h41, 8'h22, 1'b1);
    push(8'h42, 8'h33, 1'b1);
    core_dout = 8'h80;
    wait_phase(3, n);
    phase_len(3, n);
    core_dout = 8'h00;
    chk("t4_poll_len", n, 255);
    chk("t4_err_set", timeout_err, 1);
    wait_idle();
    chk("t4_err_sticky", timeout_err, 1);
    chk("t4_both_written", exp_q.size(), 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_err_clr", timeout_err, 0);

    // cen 1-in-6: every phase spans 6 clk.
    cen_div = 6;
    @(negedge clk);
    push(8'h43, 8'h44, 1'b1);
    wait_phase(1, n);
    phase_len(1, n);
    chk("t5_awr_len", n, 6);
    phase_len(0, n);
    chk("t5_await_len", n, 102);
    phase_len(2, n);
    chk("t5_dwr_len", n, 6);
    phase_len(3, n);
    chk("t5_poll_len", n, 6);
    wait_idle();
    cen_div = 1;
    @(negedge clk);

    // Flush during AWAIT of entry 1 with 4 more queued.
    cen_div = 0;
    @(negedge clk);
    push(8'h50, 8'h51, 1'b1);
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 8'h70 + 8'(i), 1'b0);
    cen_div = 1;
    wait_phase(1, n);
    repeat (3) @(negedge clk);
    chk("t6_level4", level, 4);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_reg   = 8'h77;
    wr_data  = 8'h78;
    #1;
    chk("t6_ready_flush", wr_ready, 0);
    @(negedge clk);
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("t6_level0", level, 0);
    wait_idle();
    repeat (40) @(negedge clk);
    chk("t6_only_entry1", exp_q.size(), 0);
    chk("t6_no_extra", unexpected, 0);

    // Reset mid-AWAIT with 3 entries queued.
    cen_div = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i), 8'h90 + 8'(i), 1'b1);
    cen_div = 1;
    wait_phase(1, n);
    repeat (4) @(negedge clk);
    chk("t7_level3", level, 3);
    rst_n = 1'b0;
    #1;
    chk("t7_cs_n", core_cs_n, 1);
    chk("t7_wr_n", core_wr_n, 1);
    chk("t7_addr", core_addr, 0);
    chk("t7_din", core_din, 0);
    chk("t7_level", level, 0);
    chk("t7_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("t7_level_after", level, 0);
    chk("t7_busy_after", busy, 0);

    chk("final_no_extra", unexpected, 0);
    chk("final_exp_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
